// File: rtl/trdb_branch_map_ctrl_pkg.sv
// Shared constants and types for the branch map controller.
// Snapshot payload and snapshot-register state encoding.
package trdb_branch_map_ctrl_pkg;

  localparam int MAP_LEN = 31;
  localparam int CNT_W   = $clog2(MAP_LEN + 1);

  typedef struct packed {
    logic [MAP_LEN-1:0] map;
    logic [CNT_W-1:0]   branches;
    logic               full;
  } bm_pkt_t;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } pkt_state_e;

  function automatic logic cnt_is_full(
    input logic [CNT_W-1:0] cnt
  );
    return cnt == CNT_W'(MAP_LEN);
  endfunction

endpackage

// File: rtl/trdb_branch_map_ctrl_if.sv
// Snapshot packet handshake between the branch map
// controller (master) and the packet emitter (slave).
interface trdb_branch_map_ctrl_if;
  import trdb_branch_map_ctrl_pkg::*;

  logic               pkt_valid_o;
  logic               pkt_ready_i;
  logic [MAP_LEN-1:0] pkt_map_o;
  logic [CNT_W-1:0]   pkt_branches_o;
  logic               pkt_full_o;

  modport master (
    output pkt_valid_o,
    output pkt_map_o,
    output pkt_branches_o,
    output pkt_full_o,
    input  pkt_ready_i
  );

  modport slave (
    input  pkt_valid_o,
    input  pkt_map_o,
    input  pkt_branches_o,
    input  pkt_full_o,
    output pkt_ready_i
  );

endinterface

// File: rtl/trdb_branch_map_ctrl.sv
// Sequences the trace branch map: forwards branches, decides
// flushes, and holds one snapshot for the packet emitter.
module trdb_branch_map_ctrl
  import trdb_branch_map_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               is_branch_i,
  input  logic               branch_taken_i,
  output logic               ready_o,
  input  logic               flush_req_i,
  output logic               flush_ack_o,
  output logic               bm_valid_o,
  output logic               bm_taken_o,
  output logic               bm_flush_o,
  input  logic [MAP_LEN-1:0] map_i,
  input  logic [CNT_W-1:0]   branches_i,
  input  logic               is_full_i,
  input  logic               is_empty_i,
  trdb_branch_map_ctrl_if.master pkt
);

  pkt_state_e state_q;
  pkt_state_e state_d;
  bm_pkt_t    pkt_q;
  logic       flush_pend_q;
  logic       flush_pend_d;
  logic       ack_q;
  logic       ack_d;
  logic       slot_free;
  logic       req;
  logic       flush_now;

  // A flush is only allowed when the snapshot has somewhere to go.
  always_comb begin
    slot_free = (state_q == EMPTY) | pkt.pkt_ready_i;
    req       = flush_req_i | flush_pend_q;
    flush_now = slot_free
              & (is_full_i | (req & ~is_empty_i));
  end

  assign ready_o    = ~is_full_i & ~flush_now;
  assign bm_valid_o = valid_i & is_branch_i & ready_o;
  assign bm_taken_o = branch_taken_i;
  assign bm_flush_o = flush_now;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (flush_now)
          state_d = PENDING;
      end
      PENDING: begin
        if (pkt.pkt_ready_i & ~flush_now)
          state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // An empty map satisfies a request without producing a packet.
  always_comb begin
    ack_d        = req & (flush_now | is_empty_i);
    flush_pend_d = req & ~ack_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      flush_pend_q <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      ack_q        <= ack_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_q <= '0;
    end else if (flush_now) begin
      pkt_q.map      <= map_i;
      pkt_q.branches <= branches_i;
      pkt_q.full     <= cnt_is_full(branches_i);
    end
  end

  assign flush_ack_o        = ack_q;
  assign pkt.pkt_valid_o    = (state_q == PENDING);
  assign pkt.pkt_map_o      = pkt_q.map;
  assign pkt.pkt_branches_o = pkt_q.branches;
  assign pkt.pkt_full_o     = pkt_q.full;

endmodule
